// File: rtl/crc32_pkg.sv
// Shared CRC-32 (reflected, poly 0xEDB88320) constants, FSM state type and
// byte-update function used by both the generator and the frame checker.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT  = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } crc32_state_t;

  // Advance the register over one byte, LSB first.
  function automatic logic [31:0] crc32_byte_update(input logic [31:0] crc,
                                                    input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = {1'b0, c[31:1]} ^ CRC32_POLY;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_frame_checker_byte_step.sv
// Combinational CRC-32 step: current register plus one byte gives the next register.
module crc32_byte_step
  import crc32_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] next_crc
);

  assign next_crc = crc32_byte_update(crc, data);

endmodule

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 frame checker: runs the CRC over every byte including the FCS
// and reports pass/fail, length and CRC per frame. Optional macro: CRC32_CHECK_STATS_EN.
module crc32_frame_checker
  import crc32_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  crc32_in,
  input  logic        crc32_valid_in,
  input  logic        sof_in,
  input  logic        eof_in,
  output logic        frame_done_out,
  output logic        frame_ok_out,
  output logic        len_err_out,
  output logic [15:0] frame_len_out,
  output logic [31:0] crc32_out,
  output logic [15:0] err_count_out
);

  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);
  localparam logic [15:0] MIN_LEN_C = 16'(MIN_LEN);

  crc32_state_t state_r;
  logic [31:0]  crc_r;
  logic [15:0]  len_r;
  logic         pend_r;
  logic [31:0]  pend_crc_r;

  logic [31:0]  crc_upd_s;
  logic [31:0]  crc_init_s;
  logic [15:0]  len_inc_s;
  logic         len_err_s;
  logic         rep_s;
  logic         rep_ok_s;
  logic         rep_len_err_s;
  logic [15:0]  rep_len_s;
  logic [31:0]  rep_crc_s;
  logic         dbl_s;
  logic         out_done_s;
  logic         out_ok_s;
  logic         out_len_err_s;
  logic [15:0]  out_len_s;
  logic [31:0]  out_crc_s;

  crc32_byte_step u_step_run (
    .crc      (crc_r),
    .data     (crc32_in),
    .next_crc (crc_upd_s)
  );

  crc32_byte_step u_step_init (
    .crc      (CRC32_INIT),
    .data     (crc32_in),
    .next_crc (crc_init_s)
  );

  assign len_inc_s = (len_r == 16'hFFFF) ? len_r : len_r + 16'd1;
  assign len_err_s = (len_inc_s < MIN_LEN_C) || (len_inc_s > MAX_LEN_C);

  // Decode which report, if any, the accepted byte produces.
  always_comb begin
    rep_s         = 1'b0;
    rep_ok_s      = 1'b0;
    rep_len_err_s = 1'b0;
    rep_len_s     = 16'd0;
    rep_crc_s     = 32'd0;
    dbl_s         = 1'b0;
    if (crc32_valid_in) begin
      case (state_r)
        IDLE: begin
          if (sof_in && eof_in) begin
            rep_s         = 1'b1;
            rep_len_err_s = 1'b1;
            rep_len_s     = 16'd1;
            rep_crc_s     = ~crc_init_s;
          end else begin
            rep_s = 1'b0;
          end
        end
        RECV: begin
          if (sof_in) begin
            // Aborted frame: report what arrived before the new SOF.
            rep_s     = 1'b1;
            rep_len_s = len_r;
            rep_crc_s = ~crc_r;
            dbl_s     = eof_in;
          end else if (eof_in) begin
            rep_s         = 1'b1;
            rep_len_err_s = len_err_s;
            rep_ok_s      = (crc_upd_s == CRC32_RESIDUE) && !len_err_s;
            rep_len_s     = len_inc_s;
            rep_crc_s     = crc_upd_s ^ CRC32_XOROUT;
          end else begin
            rep_s = 1'b0;
          end
        end
        default: rep_s = 1'b0;
      endcase
    end else begin
      rep_s = 1'b0;
    end
  end

  // A held one-byte result always goes out first; the rest of its fields are constant.
  always_comb begin
    out_done_s    = 1'b0;
    out_ok_s      = 1'b0;
    out_len_err_s = 1'b0;
    out_len_s     = 16'd0;
    out_crc_s     = 32'd0;
    if (pend_r) begin
      out_done_s    = 1'b1;
      out_len_err_s = 1'b1;
      out_len_s     = 16'd1;
      out_crc_s     = pend_crc_r;
    end else if (rep_s) begin
      out_done_s    = 1'b1;
      out_ok_s      = rep_ok_s;
      out_len_err_s = rep_len_err_s;
      out_len_s     = rep_len_s;
      out_crc_s     = rep_crc_s;
    end else begin
      out_done_s = 1'b0;
    end
  end

  // Frame FSM, running CRC/length, pending slot and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      crc_r          <= 32'd0;
      len_r          <= 16'd0;
      pend_r         <= 1'b0;
      pend_crc_r     <= 32'd0;
      frame_done_out <= 1'b0;
      frame_ok_out   <= 1'b0;
      len_err_out    <= 1'b0;
      frame_len_out  <= 16'd0;
      crc32_out      <= 32'd0;
    end else begin
      frame_done_out <= out_done_s;
      if (out_done_s) begin
        frame_ok_out  <= out_ok_s;
        len_err_out   <= out_len_err_s;
        frame_len_out <= out_len_s;
        crc32_out     <= out_crc_s;
      end
      pend_r     <= pend_r ? rep_s : (rep_s && dbl_s);
      pend_crc_r <= ~crc_init_s;
      if (crc32_valid_in) begin
        case (state_r)
          IDLE: begin
            if (sof_in) begin
              crc_r   <= crc_init_s;
              len_r   <= 16'd1;
              state_r <= eof_in ? IDLE : RECV;
            end
          end
          RECV: begin
            if (sof_in) begin
              crc_r   <= crc_init_s;
              len_r   <= 16'd1;
              state_r <= eof_in ? IDLE : RECV;
            end else begin
              crc_r   <= crc_upd_s;
              len_r   <= len_inc_s;
              state_r <= eof_in ? IDLE : RECV;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

`ifdef CRC32_CHECK_STATS_EN
  // Saturating count of reports with frame_ok_out low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_out <= 16'h0000;
    end else if (out_done_s && !out_ok_s && (err_count_out != 16'hFFFF)) begin
      err_count_out <= err_count_out + 16'd1;
    end else begin
      err_count_out <= err_count_out;
    end
  end
`else
  assign err_count_out = 16'h0000;
`endif

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Scoreboard bench for crc32_frame_checker: expected reports are staged with the
// driven byte and compared, including arrival cycle, when frame_done_out pulses.
module tb_crc32_frame_checker;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic        ok;
    logic        lerr;
    logic [15:0] len;
    logic [31:0] crc;
    logic [15:0] errcnt;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  crc32_in = 8'h00;
  logic        crc32_valid_in = 1'b0;
  logic        sof_in = 1'b0;
  logic        eof_in = 1'b0;
  logic        frame_done_out;
  logic        frame_ok_out;
  logic        len_err_out;
  logic [15:0] frame_len_out;
  logic [31:0] crc32_out;
  logic [15:0] err_count_out;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   model_err = 0;
  exp_t stage_q[$];
  exp_t sb_q[$];

  crc32_frame_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .crc32_in       (crc32_in),
    .crc32_valid_in (crc32_valid_in),
    .sof_in         (sof_in),
    .eof_in         (eof_in),
    .frame_done_out (frame_done_out),
    .frame_ok_out   (frame_ok_out),
    .len_err_out    (len_err_out),
    .frame_len_out  (frame_len_out),
    .crc32_out      (crc32_out),
    .err_count_out  (err_count_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bit-serial reference register (no final XOR).
  function automatic logic [31:0] model_reg(input byte_q_t q);
    logic [31:0] r;
    logic        fb;
    r = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[0] ^ q[i][b];
        r  = r >> 1;
        if (fb) r = r ^ 32'hEDB88320;
      end
    end
    return r;
  endfunction

  task automatic stage(input logic ok, input logic lerr, input int len, input logic [31:0] crc);
    exp_t x;
    if (!ok) model_err++;
    x.ok   = ok;
    x.lerr = lerr;
    x.len  = 16'(len);
    x.crc  = crc;
`ifdef CRC32_CHECK_STATS_EN
    x.errcnt = 16'(model_err);
`else
    x.errcnt = 16'h0000;
`endif
    x.due = 0;
    stage_q.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e, input int stall);
    int n;
    exp_t x;
    n = 0;
    crc32_in       = d;
    sof_in         = s;
    eof_in         = e;
    crc32_valid_in = 1'b1;
    while (stage_q.size() > 0) begin
      x     = stage_q.pop_front();
      x.due = cyc + 1 + n;
      n++;
      sb_q.push_back(x);
    end
    @(posedge clk); #1;
    crc32_valid_in = 1'b0;
    sof_in         = 1'b0;
    eof_in         = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input byte_q_t q, input int stall);
    logic [31:0] r;
    logic        lerr;
    int          last;
    last = q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      if (i == last) begin
        r    = model_reg(q);
        lerr = (q.size() < 5) || (q.size() > 1518);
        stage((r == 32'hDEBB20E3) && !lerr, lerr, q.size(), ~r);
      end
      send_byte(q[i], i == 0, i == last, (i == last) ? 0 : stall);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_value({tag, "_done"}, frame_done_out, 1'b0);
    check_value({tag, "_ok"}, frame_ok_out, 1'b0);
    check_value({tag, "_lerr"}, len_err_out, 1'b0);
    check_value({tag, "_len"}, frame_len_out, 16'h0000);
    check_value({tag, "_crc"}, crc32_out, 32'h00000000);
    check_value({tag, "_errcnt"}, err_count_out, 16'h0000);
  endtask

  // Compare every report against the scoreboard head; flag late or spurious pulses.
  always @(negedge clk) begin
    exp_t x;
    if (frame_done_out) begin
      if (sb_q.size() == 0) begin
        check_value("unexpected_done", frame_done_out, 1'b0);
      end else begin
        x = sb_q.pop_front();
        check_value("done_cycle", cyc, x.due);
        check_value("frame_ok", frame_ok_out, x.ok);
        check_value("len_err", len_err_out, x.lerr);
        check_value("frame_len", frame_len_out, x.len);
        check_value("crc32_out", crc32_out, x.crc);
        check_value("err_count", err_count_out, x.errcnt);
      end
    end
    while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      x = sb_q.pop_front();
      check_value("missed_done", cyc, x.due);
    end
  end

  initial begin
    byte_q_t good, bad, q, part;
    logic [31:0] r;

    good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer good frame, with a fixed expectation independent of the model.
    check_value("kat_residue", model_reg(good), 32'hDEBB20E3);
    send_frame(good, 0);

    bad    = good;
    bad[4] = 8'h36;
    send_frame(bad, 0);

    send_frame(good, 3);

    send_frame(good, 0);
    send_frame(good, 0);

    // Five bytes then SOF again: aborted report, then the restarted frame.
    part = {};
    for (int i = 0; i < 5; i++) begin
      part.push_back(good[i]);
      send_byte(good[i], i == 0, 1'b0, 0);
    end
    stage(1'b0, 1'b0, 5, ~model_reg(part));
    send_frame(good, 0);

    // One-byte frame from IDLE.
    q = '{8'hA5};
    stage(1'b0, 1'b1, 1, ~model_reg(q));
    send_byte(8'hA5, 1'b1, 1'b1, 0);

    // SOF+EOF in RECV: abort report followed by one-byte report.
    part = {};
    for (int i = 0; i < 3; i++) begin
      part.push_back(good[i]);
      send_byte(good[i], i == 0, 1'b0, 0);
    end
    stage(1'b0, 1'b0, 3, ~model_reg(part));
    q = '{8'h5A};
    stage(1'b0, 1'b1, 1, ~model_reg(q));
    send_byte(8'h5A, 1'b1, 1'b1, 1);

    // Maximum legal length, then one byte over, both with a correct FCS.
    for (int n = 1514; n <= 1515; n++) begin
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      r = ~model_reg(q);
      q.push_back(r[7:0]);
      q.push_back(r[15:8]);
      q.push_back(r[23:16]);
      q.push_back(r[31:24]);
      send_frame(q, 0);
    end

    // Reset after seven bytes: no report, outputs and error count cleared.
    for (int i = 0; i < 7; i++) send_byte(good[i], i == 0, 1'b0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_outputs_zero("midreset");
    rst_n     = 1'b1;
    model_err = 0;
    @(posedge clk); #1;
    check_outputs_zero("postreset");
    send_frame(good, 0);

    repeat (5) @(posedge clk);
    #1;
    check_value("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crc32_frame_checker.md
# crc32_frame_checker

Receive-side counterpart of the `crc32` byte-wise generator. It consumes a framed byte stream whose last four bytes are the transmitted FCS and runs the same reflected CRC-32 over every byte, including the FCS. At end of frame it checks the register against the CRC-32 residue and reports pass/fail, frame length and the final CRC. It sits between the byte deserializer and the frame buffer, and drives the drop/keep decision.

## Interface
- `MAX_LEN`, 1518: largest legal frame length in bytes, FCS included.
- `MIN_LEN`, 5: smallest legal frame length in bytes (1 payload byte + 4 FCS).
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `crc32_in` input 8: received byte, consumed LSB-first.
- `crc32_valid_in` input 1: byte qualifier; when low, nothing advances (stall).
- `sof_in` input 1: first byte of frame; qualified by `crc32_valid_in`.
- `eof_in` input 1: last byte of frame (last FCS byte); qualified by `crc32_valid_in`.
- `frame_done_out` output 1: one-cycle pulse when a frame result is presented.
- `frame_ok_out` output 1: CRC residue correct and length legal; valid from `frame_done_out` onward.
- `len_err_out` output 1: frame length below `MIN_LEN` or above `MAX_LEN`.
- `frame_len_out` output 16: bytes accepted in the reported frame, saturating at 16'hFFFF.
- `crc32_out` output 32: complemented CRC register over all frame bytes.
- `err_count_out` output 16: count of frames reported with `frame_ok_out`=0.

## Operation
- CRC algorithm: polynomial 0xEDB88320 (reflected), init 0xFFFFFFFF, LSB-first per byte, final XOR 0xFFFFFFFF. Identical to the generator.
- Good-frame condition: the register, before the final XOR, equals 0xDEBB20E3 after the last FCS byte. The complemented value is `crc32_out` = 0x2144DF1C.
- FSM states:
  - IDLE: bytes without `sof_in` are ignored. On an accepted byte with `sof_in`:
    - load the register with the update of init over that byte;
    - set the length to 1;
    - go to RECV, unless `eof_in` is also high.
  - RECV: each accepted byte updates the register and increments the length (saturating).
    - Byte with `eof_in`: report the result, go to IDLE.
    - Byte with `sof_in` (and no `eof_in`): report the aborted frame with `frame_ok_out`=0, `len_err_out`=0 and `frame_len_out` = bytes before the new SOF. Restart on the new byte in RECV.
    - Byte with both `sof_in` and `eof_in`: report the aborted frame, then report the one-byte frame on the next cycle. This takes two done pulses and holds a one-entry pending result.
- `sof_in` and `eof_in` on the same byte, in IDLE: a one-byte frame. `len_err_out`=1, `frame_ok_out`=0.
- `frame_ok_out` = residue match AND NOT `len_err_out`.
- The length check uses the unsaturated comparison: length > `MAX_LEN` flags an error even after saturation.
- Result outputs hold their values until the next report.
- `err_count_out` increments on every report with `frame_ok_out`=0 and saturates at 16'hFFFF.

## Timing
- Every output register is 0 after reset; the FSM resets to IDLE.
- Latency: the `frame_done_out` pulse and result fields update in the cycle after the EOF byte is accepted (1-cycle latency).
- Back-to-back frames (SOF on the cycle after EOF) are accepted at full rate with no bubble.
- Stall (`crc32_valid_in`=0) mid-frame freezes the register and the counter; any length of stall is legal.
- Reset mid-frame: the partial frame is discarded, no report is made, and `err_count_out` is cleared.

## Configuration
- `CRC32_CHECK_STATS_EN` defined: the `err_count_out` counter is built as described.
- Without it: `err_count_out` is tied to 16'h0000 and the counter is not synthesized. All other behaviour is unchanged.

## Structure
- Shared package `crc32_pkg` holds:
  - `CRC32_POLY`, `CRC32_INIT`, `CRC32_XOROUT`, `CRC32_RESIDUE` (0xDEBB20E3);
  - the FSM state typedef (IDLE, RECV);
  - the byte-update function, reused by the generator.
- One sub-module is natural: `crc32_byte_step`, a combinational 32-bit register plus 8-bit byte to next-register step.

## Test plan
- Good frame: bytes 0x31..0x39 ("123456789") then FCS 0x26,0x39,0xF4,0xCB.
  - Expect one `frame_done_out` pulse, `frame_ok_out`=1, `frame_len_out`=13, `crc32_out`=0x2144DF1C, `err_count_out`=0.
- Corrupted frame: same frame with byte 5 changed from 0x35 to 0x36.
  - Expect `frame_ok_out`=0, `len_err_out`=0, `frame_len_out`=13, `err_count_out`=1.
- Stalls: the good frame with `crc32_valid_in` low for 3 cycles between every byte.
  - Expect the identical result to the good-frame case, reported 1 cycle after EOF.
- Back-to-back good frames, then a frame with SOF re-asserted at byte 6.
  - Expect results ok, ok, then an aborted report (ok=0, len=5) followed by the restarted frame's report.
- Length errors:
  - single byte with SOF+EOF → `len_err_out`=1, len=1;
  - a 1519-byte frame with a correct FCS → `len_err_out`=1, ok=0.
- Reset asserted mid-frame after 7 bytes → no done pulse, all outputs 0. A following good frame then reports ok=1.
